// File: rtl/zap_write_buffer_if.sv
// zap_write_buffer_if: store port, load lookup port, flush control and RAM
// drain port of the ZAP write buffer. The slave modport is the buffer's view;
// the master modport is the view of the store path / memory side driving it.
interface zap_write_buffer_if #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BW    = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Store push
    logic              i_wr_en;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic [BW-1:0]     i_wr_ben;

    // Occupancy
    logic              o_full;
    logic              o_empty;
    logic [CNT_W-1:0]  o_count;

    // Load lookup
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_hit;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_hazard;

    // Flush
    logic              i_flush;
    logic              o_flush_done;

    // RAM drain port
    logic              o_ram_req;
    logic              i_ram_gnt;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_data;
    logic [BW-1:0]     o_ram_ben;
    logic              i_ram_wait;

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_wr_ben,
        output o_full, o_empty, o_count,
        input  i_rd_addr,
        output o_rd_hit, o_rd_data, o_rd_hazard,
        input  i_flush,
        output o_flush_done,
        output o_ram_req, o_ram_addr, o_ram_data, o_ram_ben,
        input  i_ram_gnt, i_ram_wait
    );

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_wr_ben,
        input  o_full, o_empty, o_count,
        output i_rd_addr,
        input  o_rd_hit, o_rd_data, o_rd_hazard,
        output i_flush,
        input  o_flush_done,
        input  o_ram_req, o_ram_addr, o_ram_data, o_ram_ben,
        output i_ram_gnt, i_ram_wait
    );
endinterface

// File: rtl/zap_write_buffer.sv
// zap_write_buffer: DEPTH-entry in-order store queue drained to RAM over a
// req/gnt/wait handshake, with an associative lookup of every queued entry
// so loads either forward the youngest matching store or stall on a hazard.
// Optional feature macro: ZAP_WB_FORWARD_EN enables store-to-load forwarding
// of fully-enabled matches; without it every match is reported as a hazard.
module zap_write_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    zap_write_buffer_if.slave  bus
);
    localparam int BW    = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BW - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ram_req_q, ram_req_d;
    logic              flush_q, flush_d;
    logic              push, pop, flush_done;

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [BW-1:0]     mem_ben_q  [DEPTH];

    logic              match;
`ifdef ZAP_WB_FORWARD_EN
    logic              match_full;
    logic [DATA_W-1:0] match_data;
`endif

    // Next-state for queue bookkeeping, drain sequencing and the flush flag.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        push    = bus.i_wr_en & ~full_q;   // full is registered: a same-cycle pop does not admit
        pop     = 1'b0;
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty_q)        state_d = S_REQ;
            S_REQ:   if (bus.i_ram_gnt)   state_d = S_WAIT;
            S_WAIT:  if (!bus.i_ram_wait) pop     = 1'b1;
            default:                      state_d = S_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        valid_d = valid_q;
        if (pop)  valid_d[rd_ptr_q] = 1'b0;
        if (push) valid_d[wr_ptr_q] = 1'b1;

        // Back-to-back drain skips IDLE whenever something is left after the pop.
        if (pop) state_d = (count_d != '0) ? S_REQ : S_IDLE;

        empty_d   = (count_d == '0);
        full_d    = (count_d == CNT_W'(DEPTH));
        ram_req_d = (state_d != S_IDLE);

        flush_done = flush_q & empty_q;
        flush_d    = (flush_q & ~flush_done) | bus.i_flush;
    end

    // Control registers; reset abandons any in-flight transfer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ram_req_q <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ram_req_q <= ram_req_d;
            flush_q   <= flush_d;
        end
    end

    // Entry payload write at the tail; addresses are stored word-aligned.
    // NOTE: payload storage is not reset; valid bits and ram_req gate every use.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= bus.i_wr_addr & WORD_MASK;
            mem_data_q[wr_ptr_q] <= bus.i_wr_data;
            mem_ben_q[wr_ptr_q]  <= bus.i_wr_ben;
        end
    end

    // Associative lookup walking oldest to youngest, so the last match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx   = rd_ptr_q;
        match = 1'b0;
`ifdef ZAP_WB_FORWARD_EN
        match_full = 1'b0;
        match_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[idx] && ((bus.i_rd_addr & WORD_MASK) == mem_addr_q[idx])) begin
                match = 1'b1;
`ifdef ZAP_WB_FORWARD_EN
                match_full = &mem_ben_q[idx];
                match_data = mem_data_q[idx];
`endif
            end
        end
    end

`ifdef ZAP_WB_FORWARD_EN
    assign bus.o_rd_hit    = match & match_full;
    assign bus.o_rd_hazard = match & ~match_full;
    assign bus.o_rd_data   = (match & match_full) ? match_data : '0;
`else
    assign bus.o_rd_hit    = 1'b0;
    assign bus.o_rd_hazard = match;
    assign bus.o_rd_data   = '0;
`endif

    // Head fields are shown only while a transfer is requested; rd_ptr is
    // frozen until the pop, so they stay stable through REQ and WAIT.
    assign bus.o_ram_req    = ram_req_q;
    assign bus.o_ram_addr   = ram_req_q ? mem_addr_q[rd_ptr_q] : '0;
    assign bus.o_ram_data   = ram_req_q ? mem_data_q[rd_ptr_q] : '0;
    assign bus.o_ram_ben    = ram_req_q ? mem_ben_q[rd_ptr_q]  : '0;

    assign bus.o_full       = full_q;
    assign bus.o_empty      = empty_q;
    assign bus.o_count      = count_q;
    assign bus.o_flush_done = flush_done;
endmodule

// File: tb/tb_zap_write_buffer.sv
// tb_zap_write_buffer: directed scenarios plus a randomized run, checked
// against a queue-based model of the write buffer's contents.
module tb_zap_write_buffer;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
    } entry_t;

    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    zap_write_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    zap_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int     vectors    = 0;
    int     miscompares = 0;
    entry_t model_q[$];   // entries held in the buffer, oldest first
    entry_t exp_q[$];     // model entries retired, in retirement order
    entry_t obs_q[$];     // RAM writes seen on the port
    bit     in_wait;
    int     step_no;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Apply one cycle of inputs at the falling edge, update the model for the
    // coming rising edge, and return at the next falling edge.
    task automatic step(input logic wr_en, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] ben, input logic gnt, input logic wt, input logic flush);
        bit can_push;
        bus.i_wr_en   = wr_en;
        bus.i_wr_addr = addr;
        bus.i_wr_data = data;
        bus.i_wr_ben  = ben;
        bus.i_ram_gnt = gnt;
        bus.i_ram_wait = wt;
        bus.i_flush   = flush;
        #1;
        if (i_reset) begin
            model_q.delete();
            in_wait = 0;
        end else begin
            can_push = (model_q.size() < DEPTH);
            if (in_wait && !wt) begin
                obs_q.push_back('{bus.o_ram_addr, bus.o_ram_data, bus.o_ram_ben});
                if (model_q.size() != 0) exp_q.push_back(model_q.pop_front());
                else exp_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF});
                in_wait = 0;
            end else if (bus.o_ram_req && !in_wait && gnt) begin
                in_wait = 1;
            end
            if (wr_en && can_push) model_q.push_back('{addr, data, ben});
        end
        @(posedge i_clk);
        @(negedge i_clk);
        step_no++;
    endtask

    task automatic idle(input logic gnt, input logic wt);
        step(1'b0, 32'h0, 32'h0, 4'h0, gnt, wt, 1'b0);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        i_reset = 1'b0;
        model_q.delete();
        exp_q.delete();
        obs_q.delete();
        in_wait = 0;
        step_no = 0;
        bus.i_rd_addr = 32'h0;
    endtask

    // Youngest-first search of the model queue.
    function automatic void model_lookup(input logic [31:0] a, output logic hit,
                                         output logic hz, output logic [31:0] d);
        hit = 1'b0;
        hz  = 1'b0;
        d   = 32'h0;
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if ((model_q[i].addr >> 2) == (a >> 2)) begin
`ifdef ZAP_WB_FORWARD_EN
                if (model_q[i].ben == 4'hF) begin
                    hit = 1'b1;
                    d   = model_q[i].data;
                end else begin
                    hz = 1'b1;
                end
`else
                hz = 1'b1;
`endif
                break;
            end
        end
    endfunction

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.o_empty, bus.o_full, bus.o_count, bus.o_ram_req} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_status: got empty/full/count/req=%b/%b/%0d/%b want 1/0/0/0",
                     bus.o_empty, bus.o_full, bus.o_count, bus.o_ram_req);
        end
        vectors++;
        if ({bus.o_ram_addr, bus.o_ram_data, bus.o_ram_ben} !== 68'h0) begin
            miscompares++;
            $display("FAIL reset_ram_fields: got %h/%h/%h want 0/0/0",
                     bus.o_ram_addr, bus.o_ram_data, bus.o_ram_ben);
        end
        vectors++;
        if ({bus.o_rd_hit, bus.o_rd_hazard, bus.o_flush_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_lookup: got hit/hazard/done=%b/%b/%b want 0/0/0",
                     bus.o_rd_hit, bus.o_rd_hazard, bus.o_flush_done);
        end
    endtask

    task automatic test_drain_order();
        int done_at[$];
        int n0;
        logic [31:0] ea [3] = '{32'h100, 32'h104, 32'h108};
        logic [31:0] ed [3] = '{32'hAA, 32'hBB, 32'hCC};
        do_reset();
        step(1'b1, 32'h100, 32'hAA, 4'hF, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.o_ram_req !== 1'b0 || bus.o_count !== 5'd1) begin
            miscompares++;
            $display("FAIL order_first_cycle: got req=%b count=%0d want req=0 count=1",
                     bus.o_ram_req, bus.o_count);
        end
        step(1'b1, 32'h104, 32'hBB, 4'hF, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (bus.o_ram_req !== 1'b1 || bus.o_ram_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL order_first_req: got req=%b addr=%h want req=1 addr=00000100",
                     bus.o_ram_req, bus.o_ram_addr);
        end
        step(1'b1, 32'h108, 32'hCC, 4'hF, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20 && obs_q.size() < 3; k++) begin
            n0 = obs_q.size();
            idle(1'b1, 1'b0);
            if (obs_q.size() > n0) done_at.push_back(step_no - 1);
        end
        vectors++;
        if (obs_q.size() != 3) begin
            miscompares++;
            $display("FAIL order_count: got %0d writes want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs_q[i].addr !== ea[i] || obs_q[i].data !== ed[i] || obs_q[i].ben !== 4'hF) begin
                    miscompares++;
                    $display("FAIL order_write%0d: got %h/%h/%h want %h/%h/f", i,
                             obs_q[i].addr, obs_q[i].data, obs_q[i].ben, ea[i], ed[i]);
                end
                vectors++;
                if (done_at[i] != 3 + 2 * i) begin
                    miscompares++;
                    $display("FAIL order_timing%0d: got step %0d want %0d", i, done_at[i], 3 + 2 * i);
                end
            end
        end
        vectors++;
        if (bus.o_empty !== 1'b1 || bus.o_ram_req !== 1'b0) begin
            miscompares++;
            $display("FAIL order_empty: got empty=%b req=%b want 1/0", bus.o_empty, bus.o_ram_req);
        end
    endtask

    task automatic test_full();
        entry_t pushed[$];
        entry_t e;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            e = '{32'h1000 + 32'(4 * i), $urandom, 4'hF};
            pushed.push_back(e);
            step(1'b1, e.addr, e.data, e.ben, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 32'h2000, 32'hDEAD_0017, 4'hF, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.o_full !== 1'b1 || bus.o_count !== 5'd16) begin
            miscompares++;
            $display("FAIL full_status: got full=%b count=%0d want full=1 count=16",
                     bus.o_full, bus.o_count);
        end
        for (int k = 0; k < 100 && obs_q.size() < DEPTH; k++) idle(1'b1, 1'b0);
        repeat (4) idle(1'b1, 1'b0);
        vectors++;
        if (obs_q.size() != DEPTH) begin
            miscompares++;
            $display("FAIL full_drain_count: got %0d writes want %0d", obs_q.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                vectors++;
                if (obs_q[i].addr !== pushed[i].addr || obs_q[i].data !== pushed[i].data) begin
                    miscompares++;
                    $display("FAIL full_drain%0d: got %h/%h want %h/%h", i,
                             obs_q[i].addr, obs_q[i].data, pushed[i].addr, pushed[i].data);
                end
            end
        end
        vectors++;
        if (bus.o_empty !== 1'b1 || bus.o_count !== 5'd0) begin
            miscompares++;
            $display("FAIL full_empty_after: got empty=%b count=%0d want 1/0", bus.o_empty, bus.o_count);
        end
    endtask

    task automatic test_forward();
        logic        eh, ez;
        logic [31:0] ed;
        do_reset();
        step(1'b1, 32'h200, 32'h11, 4'hF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h200, 32'h22, 4'hF, 1'b0, 1'b0, 1'b0);
        bus.i_rd_addr = 32'h202;
        #1;
`ifdef ZAP_WB_FORWARD_EN
        eh = 1'b1; ez = 1'b0; ed = 32'h22;
`else
        eh = 1'b0; ez = 1'b1; ed = 32'h0;
`endif
        vectors++;
        if (bus.o_rd_hit !== eh || bus.o_rd_hazard !== ez || bus.o_rd_data !== ed) begin
            miscompares++;
            $display("FAIL fwd_youngest: got hit=%b hazard=%b data=%h want %b/%b/%h",
                     bus.o_rd_hit, bus.o_rd_hazard, bus.o_rd_data, eh, ez, ed);
        end
        // A store being pushed this cycle is not yet visible to the lookup.
        bus.i_wr_en = 1'b1; bus.i_wr_addr = 32'h400; bus.i_wr_data = 32'h44; bus.i_wr_ben = 4'hF;
        bus.i_rd_addr = 32'h400;
        #1;
        vectors++;
        if (bus.o_rd_hit !== 1'b0 || bus.o_rd_hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL fwd_same_cycle: got hit=%b hazard=%b want 0/0", bus.o_rd_hit, bus.o_rd_hazard);
        end
        step(1'b1, 32'h400, 32'h44, 4'hF, 1'b0, 1'b0, 1'b0);
        #1;
        model_lookup(32'h400, eh, ez, ed);
        vectors++;
        if (bus.o_rd_hit !== eh || bus.o_rd_hazard !== ez || bus.o_rd_data !== ed) begin
            miscompares++;
            $display("FAIL fwd_next_cycle: got hit=%b hazard=%b data=%h want %b/%b/%h",
                     bus.o_rd_hit, bus.o_rd_hazard, bus.o_rd_data, eh, ez, ed);
        end
    endtask

    task automatic test_partial();
        do_reset();
        step(1'b1, 32'h300, 32'h33, 4'h3, 1'b0, 1'b0, 1'b0);
        bus.i_rd_addr = 32'h300;
        #1;
        vectors++;
        if (bus.o_rd_hit !== 1'b0 || bus.o_rd_hazard !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_hazard: got hit=%b hazard=%b want 0/1", bus.o_rd_hit, bus.o_rd_hazard);
        end
        bus.i_rd_addr = 32'h304;
        #1;
        vectors++;
        if (bus.o_rd_hit !== 1'b0 || bus.o_rd_hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_miss: got hit=%b hazard=%b want 0/0", bus.o_rd_hit, bus.o_rd_hazard);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h600 + 32'(4 * i), 32'(i), 4'hF, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        vectors++;
        if (bus.o_ram_req !== 1'b1 || bus.o_count !== 5'd5) begin
            miscompares++;
            $display("FAIL midreset_pre: got req=%b count=%0d want 1/5", bus.o_ram_req, bus.o_count);
        end
        i_reset = 1'b1;
        idle(1'b1, 1'b1);
        i_reset = 1'b0;
        vectors++;
        if ({bus.o_ram_req, bus.o_count, bus.o_empty, bus.o_ram_addr} !== {1'b0, 5'd0, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL midreset_post: got req=%b count=%0d empty=%b addr=%h want 0/0/1/0",
                     bus.o_ram_req, bus.o_count, bus.o_empty, bus.o_ram_addr);
        end
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            idle(1'b1, 1'b0);
            if (bus.o_ram_req !== 1'b0) stray++;
        end
        vectors++;
        if (stray != 0 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got %0d req cycles, %0d writes want 0/0", stray, obs_q.size());
        end
    endtask

    task automatic test_flush();
        int pulses, pulse_at, pop2_at, wcnt, n0;
        logic wt;
        do_reset();
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (bus.o_flush_done !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_empty_pulse: got done=%b want 1", bus.o_flush_done);
        end
        idle(1'b0, 1'b0);
        vectors++;
        if (bus.o_flush_done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_empty_single: got done=%b want 0", bus.o_flush_done);
        end
        step(1'b1, 32'h700, 32'h70, 4'hF, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h704, 32'h71, 4'hF, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        pulses = 0; pulse_at = -1; pop2_at = -2; wcnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (in_wait) begin
                wt = (wcnt < 3);
                wcnt++;
            end else begin
                wt = 1'b1;
                wcnt = 0;
            end
            n0 = obs_q.size();
            idle(1'b1, wt);
            if (obs_q.size() == 2 && n0 == 1) pop2_at = step_no - 1;
            if (bus.o_flush_done === 1'b1) begin
                pulses++;
                pulse_at = step_no - 1;
            end
        end
        vectors++;
        if (pulses != 1 || pulse_at != pop2_at) begin
            miscompares++;
            $display("FAIL flush_done_timing: got %0d pulses at step %0d want 1 at step %0d",
                     pulses, pulse_at, pop2_at);
        end
    endtask

    task automatic test_random();
        logic        eh, ez;
        logic [31:0] ed, a;
        int          bad;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.i_rd_addr = 32'h500 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            #1;
            model_lookup(bus.i_rd_addr, eh, ez, ed);
            vectors++;
            if (bus.o_rd_hit !== eh || bus.o_rd_hazard !== ez || bus.o_rd_data !== ed) begin
                miscompares++;
                $display("FAIL rand_lookup c=%0d addr=%h: got %b/%b/%h want %b/%b/%h", c, bus.i_rd_addr,
                         bus.o_rd_hit, bus.o_rd_hazard, bus.o_rd_data, eh, ez, ed);
            end
            vectors++;
            if (bus.o_count !== 5'(model_q.size()) || bus.o_empty !== (model_q.size() == 0) ||
                bus.o_full !== (model_q.size() == DEPTH)) begin
                miscompares++;
                $display("FAIL rand_occupancy c=%0d: got count=%0d empty=%b full=%b want count=%0d",
                         c, bus.o_count, bus.o_empty, bus.o_full, model_q.size());
            end
            if (bus.o_ram_req === 1'b1) begin
                vectors++;
                if (model_q.size() == 0 || bus.o_ram_addr !== (model_q[0].addr & ~32'h3) ||
                    bus.o_ram_data !== model_q[0].data || bus.o_ram_ben !== model_q[0].ben) begin
                    miscompares++;
                    $display("FAIL rand_head c=%0d: got %h/%h/%h with %0d queued", c,
                             bus.o_ram_addr, bus.o_ram_data, bus.o_ram_ben, model_q.size());
                end
            end
            a = 32'h500 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            step($urandom_range(0, 4) < 3, a, $urandom,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                 1'($urandom), 1'($urandom), 1'b0);
        end
        for (int k = 0; k < 100 && (model_q.size() != 0 || in_wait); k++) idle(1'b1, 1'b0);
        vectors++;
        if (obs_q.size() != exp_q.size() || model_q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_drain_count: got %0d writes want %0d (%0d left)",
                     obs_q.size(), exp_q.size(), model_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < obs_q.size(); i++) begin
                vectors++;
                if (obs_q[i].addr !== (exp_q[i].addr & ~32'h3) || obs_q[i].data !== exp_q[i].data ||
                    obs_q[i].ben !== exp_q[i].ben) begin
                    miscompares++;
                    if (bad < 5) $display("FAIL rand_write%0d: got %h/%h/%h want %h/%h/%h", i,
                                          obs_q[i].addr, obs_q[i].data, obs_q[i].ben,
                                          exp_q[i].addr & ~32'h3, exp_q[i].data, exp_q[i].ben);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        i_reset       = 1'b1;
        bus.i_wr_en   = 1'b0;
        bus.i_wr_addr = '0;
        bus.i_wr_data = '0;
        bus.i_wr_ben  = '0;
        bus.i_rd_addr = '0;
        bus.i_flush   = 1'b0;
        bus.i_ram_gnt = 1'b0;
        bus.i_ram_wait = 1'b0;
        in_wait = 0;
        step_no = 0;
        @(negedge i_clk);
        test_reset();
        test_drain_order();
        test_full();
        test_forward();
        test_partial();
        test_reset_mid();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/zap_write_buffer.md
# zap_write_buffer

Parametrised write buffer between the ZAP store path and the memory port of the MMU/cache subsystem. Stores are absorbed in a DEPTH-entry circular queue and drained in order to RAM over a req/gnt/wait handshake, letting the write-through cache retire stores without waiting for memory. All valid entries are searched associatively on every load address. Matches are either forwarded or flagged as a hazard, so loads never read stale RAM.

## Interface
- DEPTH, 16: entry count; power of two, ≥2.
- ADDR_W, 32: byte address width.
- DATA_W, 32: data width; multiple of 8. BW = DATA_W/8, OFS = log2(BW).

- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wr_en  in  1  push a store; accepted iff o_full=0.
- i_wr_addr  in  ADDR_W  store byte address. Low OFS bits are ignored.
- i_wr_data  in  DATA_W  store data.
- i_wr_ben  in  BW  byte enables.
- o_full / o_empty  out  1  count==DEPTH / count==0. Both are registered.
- o_count  out  log2(DEPTH)+1  valid entries.
- i_rd_addr  in  ADDR_W  load lookup address (combinational search).
- o_rd_hit  out  1  forward valid.
- o_rd_data  out  DATA_W  forwarded data.
- o_rd_hazard  out  1  a match exists that cannot be forwarded; the load must stall.
- i_flush  in  1  drain request pulse.
- o_flush_done  out  1  one-cycle pulse once the buffer is empty after a flush.
- o_ram_req  out  1  RAM access request.
- i_ram_gnt  in  1  access granted.
- o_ram_addr  out  ADDR_W  head word address (low OFS bits are 0).
- o_ram_data  out  DATA_W  head data.
- o_ram_ben  out  BW  head byte enables.
- i_ram_wait  in  1  RAM busy; transfer completes in a WAIT cycle with i_ram_wait=0.

## Operation
- Storage: circular queue with wr_ptr and rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH), a per-entry valid bit, and age given by pointer order.
- Push: when i_wr_en & ~o_full, write the entry at wr_ptr and increment wr_ptr.
  - i_wr_en while full is dropped silently. A pop in the same cycle does not admit it.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Drain FSM, registered state:
  - IDLE: o_ram_req=0. If ~o_empty, go to REQ.
  - REQ: o_ram_req=1. Head fields are driven and held stable. On i_ram_gnt, go to WAIT.
  - WAIT: o_ram_req=1. On ~i_ram_wait, pop the head. Go to REQ if the post-pop count >0, else go to IDLE.
- o_ram_addr, o_ram_data and o_ram_ben come from the rd_ptr entry and do not change during REQ/WAIT.
- Lookup: compare i_rd_addr[ADDR_W-1:OFS] against every valid entry, including the head currently in flight. Select the youngest match.
  - A store pushed in the current cycle is not searched until the next cycle.
- Flush: i_flush sets a sticky flag. When flag & o_empty, pulse o_flush_done and clear the flag. A flush issued while already empty pulses on the next cycle. Pushes during a flush are still accepted and extend the flush.
- Reset values (from reset and mid-operation):
  - FSM returns to IDLE; pointers, count and valid bits are cleared.
  - o_empty=1; o_full=0; o_count=0.
  - o_ram_req=0; o_ram_addr/data/ben=0.
  - o_rd_hit=0; o_rd_hazard=0; o_flush_done=0.
  - An in-flight RAM transfer is abandoned; the memory controller must tolerate o_ram_req dropping.

## Timing
- Push sampled at edge N: o_count and o_empty update after N, so the lookup sees the entry in cycle N+1. FSM enters REQ at N+2, where o_ram_req=1.
- Minimum drain per entry is 2 cycles: REQ with gnt, then WAIT with i_ram_wait=0. Back-to-back entries skip IDLE.
- o_rd_hit, o_rd_data and o_rd_hazard are combinational from i_rd_addr and registered state, with zero latency.
- o_flush_done arrives one cycle after the pop that empties the buffer.

## Configuration
- ZAP_WB_FORWARD_EN defined:
  - If the youngest match has all BW enables set: o_rd_hit=1, o_rd_data = its data, o_rd_hazard=0.
  - Partial enables give o_rd_hazard=1.
- Undefined: any match gives o_rd_hazard=1; o_rd_hit and o_rd_data are tied to 0.

## Test plan
- Reset, then push 3 stores (0x100/0xAA, 0x104/0xBB, 0x108/0xCC) with gnt=1 and wait=0 → RAM writes occur in order, first o_ram_req at cycle 2 after the push, one entry per 2 cycles, then o_empty=1.
- Fill 16 entries with gnt=0, then push a 17th → o_full=1, 17th dropped, o_count=16. Release gnt → all 16 drain in order; the 17th data never appears.
- Push 0x200/0x11 then 0x200/0x22, ben=0xF, gnt=0; lookup 0x202 → with macro: hit=1, data=0x22; without macro: hazard=1, hit=0.
- Push 0x300 with ben=0x3; lookup 0x300 → hazard=1 under both configs. Lookup 0x304 → hit=0, hazard=0.
- Assert i_reset during WAIT with 5 entries queued → next cycle: o_ram_req=0, o_count=0, o_empty=1, no further RAM requests.
- Pulse i_flush with 2 entries and i_ram_wait=1 for 3 cycles per entry → o_flush_done pulses exactly once, the cycle after the second pop.
